// File: rtl/seven_segment_scan_8_if.sv
// Display bus for the 8-digit seven-segment scanner.
// Master drives digit data; slave drives the scanned anode/segment outputs.
interface seven_segment_scan_8_if;
    logic [31:0] disp;
    logic [7:0]  disp_en;
    logic [7:0]  disp_dot;
    logic [7:0]  anodes;
    logic [7:0]  abcdefgh;
    logic        frame_start;

    modport master (
        output disp, disp_en, disp_dot,
        input  anodes, abcdefgh, frame_start
    );

    modport slave (
        input  disp, disp_en, disp_dot,
        output anodes, abcdefgh, frame_start
    );
endinterface

// File: rtl/seven_segment_scan_8.sv
// Time-multiplexed 8-digit hex seven-segment scanner, slot = 2^W_DIV clocks.
// Option: SEVEN_SEGMENT_SCAN_FRAME_LATCH_EN freezes digit data once per frame.
module seven_segment_scan_8 #(
    parameter int W_DIV = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    seven_segment_scan_8_if.slave seg_if
);

    logic [W_DIV-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             fs_q, fs_d;
    logic             tick;
    logic             frame_edge;
    logic [31:0]      src_disp;
    logic [7:0]       src_en;
    logic [7:0]       src_dot;
    logic [3:0]       digit;

    assign tick       = &div_q;
    // Scanner sits at index 0, divider 0 exactly when a new frame is shown
    assign frame_edge = (idx_q == 3'd0) && (div_q == '0);

`ifdef SEVEN_SEGMENT_SCAN_FRAME_LATCH_EN
    logic [47:0] lat_q, lat_d;

    // The frame-start clock takes live inputs and holds them for the frame
    always_comb begin
        lat_d = lat_q;
        if (frame_edge) begin
            lat_d = {seg_if.disp, seg_if.disp_en, seg_if.disp_dot};
        end
    end

    // Frame data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign {src_disp, src_en, src_dot} = lat_d;
`else
    assign src_disp = seg_if.disp;
    assign src_en   = seg_if.disp_en;
    assign src_dot  = seg_if.disp_dot;
`endif

    assign digit = src_disp[{idx_q, 2'b00} +: 4];

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        g = 7'b0000000;
        case (d)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            4'hF: g = 7'b1000111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    // Divider/index advance and the next registered display word
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        fs_d  = frame_edge;
        if (tick) begin
            idx_d = idx_q + 3'd1;
        end
        if (src_en[idx_q]) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = {~hex_glyph(digit), ~src_dot[idx_q]};
        end
    end

    // Scan state and output registers; one register stage means no glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= 3'd0;
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            fs_q  <= fs_d;
        end
    end

    assign seg_if.anodes      = an_q;
    assign seg_if.abcdefgh    = seg_q;
    assign seg_if.frame_start = fs_q;

endmodule

// File: doc/seven_segment_scan_8.md
SEVEN_SEGMENT_SCAN_8 -- requirements
Module: seven_segment_scan_8

Interface
REQ-001 Parameter: W_DIV, default 16, width of the slot-length divider; each digit slot lasts 2^W_DIV clocks.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 disp  input  32  eight hex digits; digit i = disp[4i+3:4i], digit 0 rightmost.
REQ-005 disp_en  input  8  per-digit enable; 1 = digit lit.
REQ-006 disp_dot  input  8  per-digit decimal point; 1 = dot lit.
REQ-007 anodes  output  8  digit select, active-low, at most one bit low.
REQ-008 abcdefgh  output  8  segments a..g in bits 7..1 and dot in bit 0, all active-low.
REQ-009 frame_start  output  1  one-clock pulse when the scan returns to digit 0.

Function
REQ-010 A W_DIV-bit divider counter shall increment every clock and wrap from 2^W_DIV-1 to 0.
REQ-011 The cycle in which the divider equals 2^W_DIV-1 is the slot tick; the 3-bit digit index shall advance on each slot tick, wrapping from 7 to 0.
REQ-012 anodes, abcdefgh and frame_start shall be registered; they reflect the digit index and the source data with exactly one clock of latency.
REQ-013 For index i with source disp_en[i]=1: anodes bit i shall be 0, all other bits 1; segments shall show the hex glyph of digit i; bit 0 shall be ~disp_dot[i].
REQ-014 For index i with source disp_en[i]=0: anodes shall be 8'hFF and abcdefgh 8'hFF for the whole slot.
REQ-015 Hex glyphs (abcdefg, 1 = lit before inversion): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-016 frame_start shall be 1 for exactly one clock: the first clock in which the registered outputs show index 0.
REQ-017 Between a slot tick and the registered output change there shall be no glitch cycle with two anodes low.

Reset
REQ-018 While rst_n=0: divider=0, index=0, anodes=8'hFF, abcdefgh=8'hFF, frame_start=0, frame latch (if present) cleared to 0.
REQ-019 Reset asserted mid-slot shall force the values of REQ-018 immediately, without waiting for clk.
REQ-020 After release, the first clock shall drive index 0 on the outputs and pulse frame_start.

Configuration
REQ-021 Macro SEVEN_SEGMENT_SCAN_FRAME_LATCH_EN.
REQ-022 Defined: disp, disp_en and disp_dot shall be captured into an internal latch register on the clock whose next state is index 0 with divider 0, including the first clock after reset; the source data for REQ-013/014 shall be the latch; input changes mid-frame shall not appear until the next frame.
REQ-023 Undefined: no latch register; the source data shall be the live inputs, and a change shall appear on abcdefgh one clock later, even mid-slot.

Verification (W_DIV=2: slot 4 clocks, frame 32 clocks)
REQ-024 Reset, disp=32'h76543210, disp_en=8'hFF, disp_dot=8'h00 -> anodes cycle FE,FD,FB,...,7F, each held 4 clocks; digit 0 abcdefgh=8'b00000011, digit 7 abcdefgh=8'b00011111; frame_start high every 32nd clock.
REQ-025 disp_en=8'b01010101 -> slots 1,3,5,7 show anodes=FF and abcdefgh=FF; slots 0,2,4,6 show normally.
REQ-026 disp_dot=8'h01, disp[3:0]=4'h8 -> abcdefgh=8'h00 during slot 0 only.
REQ-027 Change disp from 32'h0 to 32'hFFFFFFFF in slot 3 -> without macro, slot 3 glyph changes one clock later; with macro, slots 3-7 still show 0, and F appears from the next frame_start.
REQ-028 Drop rst_n between clock edges mid-slot 5 -> anodes and abcdefgh go to FF at once; after release, index 0 is shown on the first clock and frame_start pulses.
REQ-029 Every clock, check that at most one anodes bit is 0 and that frame_start never lasts 2 clocks.
